// File: rtl/if_stage_if.sv
// if_stage_if -- bus bundle between the instruction-fetch stage, the PC
// register, the instruction memory and decode.
// Optional feature macro: IF_ALIGN_CHECK_EN (adds the misalign strobe).
//
// Handshake rules:
//   - Decode side: the head entry transfers on a rising clk edge where
//     instr_valid and id_ready are both high. instr_valid never depends on
//     id_ready. flush overrides everything and empties the queue.
//   - Memory side: imem_req is a one-cycle strobe that qualifies imem_addr.
//     Exactly one response (imem_rvalid with imem_rdata) follows each strobe,
//     no earlier than the cycle after the strobe. At most one request is
//     outstanding.
//   - PC side: pc_adv is a one-cycle pulse. The PC register loads its next
//     value on the edge that samples it.

interface if_stage_if;
  logic [31:0] pc_in;
  logic        pc_adv;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        id_ready;
  logic        flush;
`ifdef IF_ALIGN_CHECK_EN
  logic        misalign;
`endif

`ifdef IF_ALIGN_CHECK_EN
  // Fetch-stage view.
  modport master (
    input  pc_in, imem_rvalid, imem_rdata, id_ready, flush,
    output pc_adv, imem_req, imem_addr, instr_valid, instr, instr_pc,
           misalign
  );

  // Environment view: PC register, instruction memory and decode.
  modport slave (
    output pc_in, imem_rvalid, imem_rdata, id_ready, flush,
    input  pc_adv, imem_req, imem_addr, instr_valid, instr, instr_pc,
           misalign
  );
`else
  // Fetch-stage view.
  modport master (
    input  pc_in, imem_rvalid, imem_rdata, id_ready, flush,
    output pc_adv, imem_req, imem_addr, instr_valid, instr, instr_pc
  );

  // Environment view: PC register, instruction memory and decode.
  modport slave (
    output pc_in, imem_rvalid, imem_rdata, id_ready, flush,
    input  pc_adv, imem_req, imem_addr, instr_valid, instr, instr_pc
  );
`endif
endinterface

// File: rtl/if_stage.sv
// if_stage -- instruction-fetch stage.
//
// Issues one instruction-memory request at a time. The request address is
// the current PC. Each response goes into a 2-entry {pc, instr} queue that
// feeds decode. A request issues only while the queue has a free slot, so
// the response always has room to land.
//
// Optional feature macro: IF_ALIGN_CHECK_EN. When defined, a fetch from a
// PC whose low two bits are not zero is refused. The misalign output pulses
// instead of issuing the request. When the macro is undefined, pc_in is
// used unmodified.
//
// fsm_state exposes the FSM state for observation:
//   0 = IDLE, 1 = WAIT, 2 = DROP.

module if_stage (
  input  logic        clk,
  input  logic        reset,
  if_stage_if.master  bus,
  output logic [1:0]  fsm_state
);

  // IDLE: free to issue.
  // WAIT: a request is outstanding and its response is wanted.
  // DROP: a request is outstanding but a flush made its response stale.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t      state;

  // Registered request-side outputs.
  logic        imem_req_q;
  logic        pc_adv_q;
  logic [31:0] imem_addr_q;

  // PC of the outstanding request. It tags the response when it arrives.
  logic [31:0] req_pc;

`ifdef IF_ALIGN_CHECK_EN
  logic        misalign_q;
  logic        misalign_hit;
`endif

  // Two-entry queue storage. The pointers are one bit wide because the
  // queue has exactly two slots. count tells full apart from empty.
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;

  logic        q_empty;
  logic        q_full;
  logic        pop;
  logic        push;
  logic        fetch_try;
  logic        issue;

  assign q_empty = (count == 2'd0);
  assign q_full  = (count == 2'd2);

  // A pop with the queue empty never happens, because pop is qualified by
  // occupancy.
  assign pop = !q_empty && bus.id_ready;

  // A response is kept only in WAIT and only when no flush makes it stale.
  // When the queue is full it can land only if the head leaves in the
  // same cycle.
  assign push = (state == WAIT) && bus.imem_rvalid && !bus.flush &&
                (!q_full || pop);

  // An issue is considered only with a slot free for the response. The
  // test uses the current occupancy, not the occupancy after this cycle's
  // pop.
  assign fetch_try = (state == IDLE) && !bus.flush && !q_full;

`ifdef IF_ALIGN_CHECK_EN
  assign misalign_hit = fetch_try && (bus.pc_in[1:0] != 2'b00);
  assign issue        = fetch_try && !misalign_hit;
`else
  assign issue        = fetch_try;
`endif

  // Fetch sequencing, request strobe, PC-advance pulse and address register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      imem_req_q  <= 1'b0;
      pc_adv_q    <= 1'b0;
      imem_addr_q <= 32'd0;
      req_pc      <= 32'd0;
`ifdef IF_ALIGN_CHECK_EN
      misalign_q  <= 1'b0;
`endif
    end else begin
      // imem_req and pc_adv are single-cycle pulses by default.
      imem_req_q <= 1'b0;
      pc_adv_q   <= 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      misalign_q <= misalign_hit;
`endif
      case (state)
        IDLE: begin
          // imem_rvalid is ignored here. A late response to a request that
          // was abandoned by reset must not be queued.
          if (issue) begin
            imem_req_q  <= 1'b1;
            pc_adv_q    <= 1'b1;
            imem_addr_q <= bus.pc_in;
            req_pc      <= bus.pc_in;
            state       <= WAIT;
          end
        end
        WAIT: begin
          // The response ends the request whether or not it is kept. With
          // no response yet, a flush means the response will be stale.
          if (bus.imem_rvalid) begin
            state <= IDLE;
          end else if (bus.flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (bus.imem_rvalid) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Queue update: flush empties it, otherwise push and pop act together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      q_pc[0]    <= 32'd0;
      q_pc[1]    <= 32'd0;
      q_instr[0] <= 32'd0;
      q_instr[1] <= 32'd0;
    end else if (bus.flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      // When the queue is full, wr_ptr equals rd_ptr. A push then reuses
      // the head slot that the pop is releasing on this same edge.
      if (push) begin
        q_pc[wr_ptr]    <= req_pc;
        q_instr[wr_ptr] <= bus.imem_rdata;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.pc_adv      = pc_adv_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = !q_empty;
  assign bus.instr       = q_instr[rd_ptr];
  assign bus.instr_pc    = q_pc[rd_ptr];
`ifdef IF_ALIGN_CHECK_EN
  assign bus.misalign    = misalign_q;
`endif

  assign fsm_state = state;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage -- directed bench for if_stage.
// The bench drives the PC, the instruction memory and decode by hand, one
// cycle at a time. Outputs are observed 1 ns after each rising edge.
// Inputs for the next edge are set at that same point.
// The misalignment scenario follows IF_ALIGN_CHECK_EN.

module tb_if_stage;

  localparam logic [31:0] ST_IDLE = 32'd0;
  localparam logic [31:0] ST_WAIT = 32'd1;
  localparam logic [31:0] ST_DROP = 32'd2;

  logic       clk;
  logic       reset;
  logic [1:0] fsm_state;

  int n_cmp;
  int n_fail;

  if_stage_if bus ();

  if_stage dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // Clock and watchdog.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc, input logic rdy);
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.id_ready    = rdy;
    bus.pc_in       = pc;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard helpers.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic req, input logic adv, input logic [31:0] addr);
    check({tag, "_req"}, {31'd0, bus.imem_req}, {31'd0, req});
    check({tag, "_adv"}, {31'd0, bus.pc_adv}, {31'd0, adv});
    check({tag, "_addr"}, bus.imem_addr, addr);
  endtask

  task automatic chk_head(input string tag, input logic vld, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, "_valid"}, {31'd0, bus.instr_valid}, {31'd0, vld});
    if (vld) begin
      check({tag, "_pc"}, bus.instr_pc, pc);
      check({tag, "_instr"}, bus.instr, ins);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] st);
    check({tag, "_state"}, {30'd0, fsm_state}, st);
  endtask

  initial begin
    n_cmp           = 0;
    n_fail          = 0;
    reset           = 1'b1;
    bus.pc_in       = 32'd0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'd0;
    bus.id_ready    = 1'b0;
    bus.flush       = 1'b0;

    // Reset values.
    do_reset(32'h0, 1'b1);
    chk_req("rst", 1'b0, 1'b0, 32'h0);
    chk_state("rst", ST_IDLE);
    check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_ipc", bus.instr_pc, 32'd0);

    // Basic fetch with memory latency 1 and decode always ready.
    tick();
    chk_req("a_c1", 1'b1, 1'b1, 32'h0);
    chk_state("a_c1", ST_WAIT);
    bus.pc_in = 32'h4;
    tick();
    chk_req("a_c2", 1'b0, 1'b0, 32'h0);
    chk_head("a_c2", 1'b0, 32'h0, 32'h0);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0013;
    tick();
    chk_head("a_c3", 1'b1, 32'h0, 32'h0000_0013);
    chk_req("a_c3", 1'b0, 1'b0, 32'h0);
    chk_state("a_c3", ST_IDLE);
    bus.imem_rvalid = 1'b0;
    tick();
    chk_req("a_c4", 1'b1, 1'b1, 32'h4);
    chk_head("a_c4", 1'b0, 32'h0, 32'h0);

    // Decode stalled: two entries buffer, then the third fetch waits for a
    // pop. Order 0x0, 0x4, 0x8 comes out, with push and pop on one edge.
    do_reset(32'h0, 1'b0);
    tick();
    chk_req("b_c1", 1'b1, 1'b1, 32'h0);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hA000_0000;
    tick();
    chk_head("b_c3", 1'b1, 32'h0, 32'hA000_0000);
    bus.imem_rvalid = 1'b0;
    bus.pc_in       = 32'h4;
    tick();
    chk_req("b_c4", 1'b1, 1'b1, 32'h4);
    chk_head("b_c4", 1'b1, 32'h0, 32'hA000_0000);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hA000_0004;
    tick();
    chk_state("b_c6", ST_IDLE);
    bus.imem_rvalid = 1'b0;
    bus.pc_in       = 32'h8;
    tick();
    chk_req("b_c7_full", 1'b0, 1'b0, 32'h4);
    tick();
    chk_req("b_c8_full", 1'b0, 1'b0, 32'h4);
    chk_head("b_c8", 1'b1, 32'h0, 32'hA000_0000);
    bus.id_ready = 1'b1;
    tick();
    chk_req("b_c9", 1'b0, 1'b0, 32'h4);
    chk_head("b_c9", 1'b1, 32'h4, 32'hA000_0004);
    bus.id_ready = 1'b0;
    tick();
    chk_req("b_c10", 1'b1, 1'b1, 32'h8);
    chk_head("b_c10", 1'b1, 32'h4, 32'hA000_0004);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hA000_0008;
    bus.id_ready    = 1'b1;
    tick();
    chk_head("b_c12_pushpop", 1'b1, 32'h8, 32'hA000_0008);
    chk_state("b_c12", ST_IDLE);
    bus.imem_rvalid = 1'b0;
    bus.id_ready    = 1'b0;
    bus.pc_in       = 32'hC;
    tick();
    chk_req("b_c13", 1'b1, 1'b1, 32'hC);
    chk_head("b_c13", 1'b1, 32'h8, 32'hA000_0008);

    // Flush during WAIT with a buffered entry. The stale response arrives
    // two cycles later and is dropped. The next fetch uses the new PC.
    do_reset(32'h40, 1'b0);
    tick();
    chk_req("c_c1", 1'b1, 1'b1, 32'h40);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h1234_5678;
    tick();
    chk_head("c_c3", 1'b1, 32'h40, 32'h1234_5678);
    bus.imem_rvalid = 1'b0;
    bus.pc_in       = 32'h44;
    tick();
    chk_req("c_c4", 1'b1, 1'b1, 32'h44);
    bus.flush = 1'b1;
    bus.pc_in = 32'h100;
    tick();
    chk_head("c_c5_flushed", 1'b0, 32'h0, 32'h0);
    chk_state("c_c5", ST_DROP);
    chk_req("c_c5", 1'b0, 1'b0, 32'h44);
    bus.flush = 1'b0;
    tick();
    chk_state("c_c6", ST_DROP);
    chk_req("c_c6_nodrop_req", 1'b0, 1'b0, 32'h44);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    tick();
    chk_state("c_c7", ST_IDLE);
    chk_head("c_c7_dropped", 1'b0, 32'h0, 32'h0);
    chk_req("c_c7", 1'b0, 1'b0, 32'h44);
    bus.imem_rvalid = 1'b0;
    tick();
    chk_req("c_c8_newpc", 1'b1, 1'b1, 32'h100);
    chk_head("c_c8", 1'b0, 32'h0, 32'h0);

    // Flush on the same edge as the response, then flush in IDLE, which
    // holds back the request.
    do_reset(32'h200, 1'b0);
    tick();
    chk_req("d_c1", 1'b1, 1'b1, 32'h200);
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hCAFE_0001;
    bus.flush       = 1'b1;
    tick();
    chk_state("d_c3", ST_IDLE);
    chk_head("d_c3_discard", 1'b0, 32'h0, 32'h0);
    bus.imem_rvalid = 1'b0;
    bus.pc_in       = 32'h204;
    tick();
    chk_req("d_c4_flush_idle", 1'b0, 1'b0, 32'h200);
    chk_state("d_c4", ST_IDLE);
    bus.flush = 1'b0;
    tick();
    chk_req("d_c5", 1'b1, 1'b1, 32'h204);

    // Reset mid-WAIT takes priority over push and pop. A late response
    // that arrives in IDLE is ignored.
    do_reset(32'h300, 1'b0);
    tick();
    tick();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0055;
    tick();
    chk_head("e_c3", 1'b1, 32'h300, 32'h0000_0055);
    bus.imem_rvalid = 1'b0;
    bus.pc_in       = 32'h304;
    tick();
    chk_req("e_c4", 1'b1, 1'b1, 32'h304);
    reset           = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0000_0077;
    bus.id_ready    = 1'b1;
    tick();
    chk_state("e_c5_rst", ST_IDLE);
    chk_req("e_c5_rst", 1'b0, 1'b0, 32'h0);
    check("e_c5_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check("e_c5_rst_instr", bus.instr, 32'd0);
    check("e_c5_rst_ipc", bus.instr_pc, 32'd0);
    reset           = 1'b0;
    bus.imem_rdata  = 32'h0000_0099;
    bus.id_ready    = 1'b0;
    tick();
    chk_req("e_c6", 1'b1, 1'b1, 32'h304);
    chk_head("e_c6_late_ignored", 1'b0, 32'h0, 32'h0);
    chk_state("e_c6", ST_WAIT);
    bus.imem_rvalid = 1'b0;
    tick();
    chk_head("e_c7", 1'b0, 32'h0, 32'h0);
    chk_state("e_c7", ST_WAIT);

    // Misaligned PC handling.
    do_reset(32'h6, 1'b0);
`ifdef IF_ALIGN_CHECK_EN
    tick();
    check("f_c1_misalign", {31'd0, bus.misalign}, 32'd1);
    chk_req("f_c1", 1'b0, 1'b0, 32'h0);
    chk_state("f_c1", ST_IDLE);
    bus.pc_in = 32'h8;
    tick();
    check("f_c2_misalign", {31'd0, bus.misalign}, 32'd0);
    chk_req("f_c2", 1'b1, 1'b1, 32'h8);
    chk_state("f_c2", ST_WAIT);
`else
    tick();
    chk_req("f_c1_noalign", 1'b1, 1'b1, 32'h6);
    chk_state("f_c1", ST_WAIT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
